// File: rtl/pf_stats_csr.sv
// Packet-filter statistics CSR block: per-port saturating event counters,
// clear/snapshot control and a drop-threshold interrupt on an Avalon-MM slave.
// Optional shadow snapshot registers are built when PF_STATS_SNAPSHOT_EN is defined.

module pf_stats_port #(
   parameter int CTR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [5:0]                inc,
   input  logic                      clear,
   input  logic                      snap,
   input  logic                      rd_live,
   input  logic [CTR_WIDTH-1:0]      drop_thr,
   output logic [5:0][CTR_WIDTH-1:0] rd_cnt,
   output logic                      drop_hit
);
   localparam logic [CTR_WIDTH-1:0] MAX = '1;

   logic [5:0][CTR_WIDTH-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         for (int e = 0; e < 6; e++) begin
            if (clear)
               cnt[e] <= '0;
            else if (inc[e] && cnt[e] != MAX)
               cnt[e] <= cnt[e] + CTR_WIDTH'(1);
         end
      end
   end

   // Fires only on the increment that lands exactly on the threshold.
   assign drop_hit = inc[5] && !clear && (cnt[5] != MAX) && (drop_thr != '0) &&
                     ((cnt[5] + CTR_WIDTH'(1)) == drop_thr);

`ifdef PF_STATS_SNAPSHOT_EN
   logic [5:0][CTR_WIDTH-1:0] shadow;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         shadow <= '0;
      else if (snap)
         shadow <= cnt;
   end

   assign rd_cnt = rd_live ? cnt : shadow;
`else
   logic unused_snap;
   assign unused_snap = snap ^ rd_live;
   assign rd_cnt      = cnt;
`endif
endmodule

module pf_stats_csr #(
   parameter int NUM_PORTS  = 4,
   parameter int CTR_WIDTH  = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [31:0]           writedata,
   output logic [31:0]           readdata,
   input  logic [NUM_PORTS-1:0]  in_pkt_inc,
   input  logic [NUM_PORTS-1:0]  transf_pkt_inc,
   input  logic [NUM_PORTS-1:0]  in_frame_inc,
   input  logic [NUM_PORTS-1:0]  transf_frame_inc,
   input  logic [NUM_PORTS-1:0]  inv_frame_inc,
   input  logic [NUM_PORTS-1:0]  drop_frame_inc,
   output logic [NUM_PORTS-1:0]  port_en,
   output logic                  irq
);
   logic [7:0] addr;
   logic [3:0] grp, idx;
   logic       wr_en, rd_en, ctrl_wr, clear_all, snap, rd_live;
   logic [NUM_PORTS-1:0]                      irq_status, irq_mask, drop_hit, w1c;
   logic [CTR_WIDTH-1:0]                      drop_thr;
   logic [NUM_PORTS-1:0][5:0]                 inc;
   logic [NUM_PORTS-1:0][5:0][CTR_WIDTH-1:0]  rd_cnt;
   logic [31:0]                               rd_val;
   logic                                      unused_bits;

   assign addr      = address[7:0];
   assign grp       = addr[7:4];
   assign idx       = addr[3:0];
   assign wr_en     = chipselect & write;
   assign rd_en     = chipselect & read;
   assign ctrl_wr   = wr_en && (addr == 8'h01);
   assign clear_all = ctrl_wr & writedata[1];
   assign w1c       = (wr_en && addr == 8'h02) ? writedata[NUM_PORTS-1:0] : '0;
   assign unused_bits = ^{address, writedata};

`ifdef PF_STATS_SNAPSHOT_EN
   logic snap_on_rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         snap_on_rd <= 1'b0;
      else if (ctrl_wr)
         snap_on_rd <= writedata[2];
   end

   // A read of 0x10 in snap-on-read mode returns the value being captured.
   assign snap    = (ctrl_wr & writedata[0]) | (rd_en & snap_on_rd & (addr == 8'h10));
   assign rd_live = snap_on_rd & (addr == 8'h10);
`else
   assign snap    = 1'b0;
   assign rd_live = 1'b0;
`endif

   // Event order within a port matches counter groups 1..6.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_inc
      assign inc[p] = {drop_frame_inc[p], inv_frame_inc[p], transf_frame_inc[p],
                       in_frame_inc[p], transf_pkt_inc[p], in_pkt_inc[p]};
   end

   pf_stats_port #(.CTR_WIDTH(CTR_WIDTH)) u_port [NUM_PORTS-1:0] (
      .clk      (clk),
      .reset    (reset),
      .inc      (inc),
      .clear    (clear_all),
      .snap     (snap),
      .rd_live  (rd_live),
      .drop_thr (drop_thr),
      .rd_cnt   (rd_cnt),
      .drop_hit (drop_hit)
   );

   always_comb begin
      rd_val = '0;
      if (grp == 4'h0) begin
         case (idx)
            4'h0:    rd_val = 32'(port_en);
            4'h2:    rd_val = 32'(irq_status);
            4'h3:    rd_val = 32'(irq_mask);
            4'h4:    rd_val = 32'(drop_thr);
            default: rd_val = '0;
         endcase
      end else begin
         for (int p = 0; p < NUM_PORTS; p++)
            for (int g = 0; g < 6; g++)
               if (grp == 4'(g + 1) && idx == 4'(p))
                  rd_val = 32'(rd_cnt[p][g]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         port_en    <= '0;
         irq_mask   <= '0;
         drop_thr   <= '0;
         irq_status <= '0;
         irq        <= 1'b0;
         readdata   <= '0;
      end else begin
         if (wr_en && addr == 8'h00) port_en  <= writedata[NUM_PORTS-1:0];
         if (wr_en && addr == 8'h03) irq_mask <= writedata[NUM_PORTS-1:0];
         if (wr_en && addr == 8'h04) drop_thr <= writedata[CTR_WIDTH-1:0];
         irq_status <= (irq_status & ~w1c) | drop_hit;
         irq        <= |(irq_status & irq_mask);
         if (rd_en) readdata <= rd_val;
      end
   end
endmodule
